// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with exact 50% duty cycle.
// Divisor changes are handshaked and applied only at output-period boundaries.
module clk_divider_prog #(
   parameter int W         = 8,
   parameter int DIV_RESET = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] div_in,
   input  logic         div_load,
   output logic         div_ack,
   output logic         div_err,
   output logic         busy,
   output logic [W-1:0] div_cur,
   output logic         tick,
   output logic         clk_out
);

   localparam logic [W-1:0] N_RST = W'(DIV_RESET);
   localparam logic [W-1:0] N_MIN = W'(2);
   localparam logic [W-1:0] ONE   = W'(1);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] n_cur_q, n_cur_d;
   logic [W-1:0] n_pend_q, n_pend_d;
   logic         run_q, run_d;
   logic         pend_q, pend_d;
   logic         pos_q, pos_d;
   logic         neg_q, neg_d;
   logic         ack_q, ack_d;
   logic         err_q, err_d;
   logic         tick_q, tick_d;

   logic         bnd;
   logic         apply;
   logic         req_ok;

   always_comb begin
      bnd    = en & (~run_q | (cnt_q == (n_cur_q - ONE)));
      apply  = (bnd | ~en) & pend_q;
      req_ok = div_load & (div_in >= N_MIN);

      cnt_d    = '0;
      run_d    = en;
      tick_d   = bnd;
      pos_d    = 1'b0;
      n_cur_d  = n_cur_q;
      n_pend_d = n_pend_q;
      pend_d   = pend_q;
      ack_d    = apply;
      err_d    = div_load & ~req_ok;

      if (en && !bnd) begin
         cnt_d = cnt_q + ONE;
      end

      if (apply) begin
         n_cur_d = n_pend_q;
         pend_d  = 1'b0;
      end

      // A request on the apply edge becomes the next pending value.
      if (req_ok) begin
         n_pend_d = div_in;
         pend_d   = 1'b1;
      end

      if (en) begin
         pos_d = (cnt_d < (n_cur_d >> 1));
      end

      neg_d = pos_q & n_cur_q[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         run_q    <= 1'b0;
         n_cur_q  <= N_RST;
         n_pend_q <= '0;
         pend_q   <= 1'b0;
         pos_q    <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         n_cur_q  <= n_cur_d;
         n_pend_q <= n_pend_d;
         pend_q   <= pend_d;
         pos_q    <= pos_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         tick_q   <= tick_d;
      end
   end

   // Half-cycle extension of the high phase for odd divisors.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
      end
   end

   assign div_ack = ack_q;
   assign div_err = err_q;
   assign busy    = pend_q;
   assign div_cur = n_cur_q;
   assign tick    = tick_q;
   assign clk_out = pos_q | neg_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: period-level reference model,
// directed scenarios and randomized load/enable/reset traffic.
module tb_clk_divider_prog;

   localparam int W  = 8;
   localparam int DR = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [W-1:0] div_in;
   logic         div_load;
   logic         div_ack;
   logic         div_err;
   logic         busy;
   logic [W-1:0] div_cur;
   logic         tick;
   logic         clk_out;

   clk_divider_prog #(.W(W), .DIV_RESET(DR)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .busy     (busy),
      .div_cur  (div_cur),
      .tick     (tick),
      .clk_out  (clk_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d",
                  name, $time, act, exp);
      end
   endtask

   // Reference model: a period starts at a tick and lasts N cycles;
   // the output is high for the first N half-cycles of it.
   int m_cyc   = 0;
   int m_start = 0;
   int m_n     = DR;
   int m_pval  = 0;
   bit m_run   = 0;
   bit m_pend  = 0;
   bit m_dc    = 0;
   bit e_tick  = 0;
   bit e_ack   = 0;
   bit e_err   = 0;
   bit m_b;
   bit m_app;

   always @(posedge clk) begin
      m_cyc++;
      if (rst) begin
         m_run  = 0;
         m_n    = DR;
         m_pend = 0;
         m_pval = 0;
         m_dc   = 0;
         e_tick = 0;
         e_ack  = 0;
         e_err  = 0;
         m_start = m_cyc;
      end else begin
         m_b   = en && (!m_run || (m_cyc - m_start) == m_n);
         m_app = (m_b || !en) && m_pend;
         m_dc  = !en && m_run;
         e_tick = m_b;
         e_ack  = m_app;
         e_err  = div_load && (int'(div_in) < 2);
         if (m_app) begin
            m_n    = m_pval;
            m_pend = 0;
         end
         if (div_load && int'(div_in) >= 2) begin
            m_pend = 1;
            m_pval = int'(div_in);
         end
         if (!en) m_run = 0;
         if (m_b) begin
            m_run   = 1;
            m_start = m_cyc;
         end
      end
   end

   task automatic check_all(input bit neg_ph);
      int h;
      bit e_clk;
      if (rst) begin
         chk("rst_clk_out", clk_out, 0);
         chk("rst_tick", tick, 0);
         chk("rst_ack", div_ack, 0);
         chk("rst_err", div_err, 0);
         chk("rst_busy", busy, 0);
         chk("rst_div_cur", div_cur, DR);
      end else begin
         h = 2 * (m_cyc - m_start) + int'(neg_ph);
         e_clk = m_run && (h < m_n);
         chk("tick", tick, e_tick);
         chk("div_ack", div_ack, e_ack);
         chk("div_err", div_err, e_err);
         chk("busy", busy, m_pend);
         chk("div_cur", div_cur, m_n);
         if (!(m_dc && !neg_ph)) chk("clk_out", clk_out, e_clk);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1 check_all(0);
         @(negedge clk);
         #1 check_all(1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_out(input bit use_ack, output bit ok);
      ok = 0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         if (use_ack ? div_ack : tick) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_out(%0d) timeout at %0t: got none, expected pulse",
                  use_ack, $time);
      end
   endtask

   task automatic measure(input int eh, input int ep);
      bit ok;
      int hi;
      int per;
      wait_out(0, ok);
      if (!ok) return;
      hi  = 0;
      per = 0;
      for (int h = 0; h < 200; h++) begin
         if (h > 0) begin
            if (h % 2 == 1) begin
               @(negedge clk);
               #1;
            end else begin
               @(posedge clk);
               #1;
               if (tick) begin
                  per = h / 2;
                  break;
               end
            end
         end
         if (clk_out) hi++;
      end
      chk("meas_high_halfcycles", hi, eh);
      chk("meas_period", per, ep);
      #1;
   endtask

   bit ok;
   int acks;

   initial begin
      rst = 1'b1;
      en = 1'b0;
      div_load = 1'b0;
      div_in = '0;
      step(3);
      chk("lit_rst_div_cur", div_cur, 2);
      chk("lit_rst_clk_out", clk_out, 0);
      rst = 1'b0;
      step(1);
      en = 1'b1;
      measure(2, 2);
      chk("lit_div_cur_2", div_cur, 2);

      en = 1'b0;
      div_in = 8'd5;
      div_load = 1'b1;
      step(1);
      div_load = 1'b0;
      chk("lit_busy_disabled", busy, 1);
      step(1);
      chk("lit_ack_disabled", div_ack, 1);
      chk("lit_div_cur_5", div_cur, 5);
      en = 1'b1;
      measure(5, 5);

      en = 1'b0;
      div_in = 8'd6;
      div_load = 1'b1;
      step(1);
      div_load = 1'b0;
      step(2);
      chk("lit_div_cur_6", div_cur, 6);
      en = 1'b1;
      wait_out(0, ok);
      step(2);
      div_in = 8'd3;
      div_load = 1'b1;
      step(1);
      div_load = 1'b0;
      chk("lit_busy_running", busy, 1);
      chk("lit_div_cur_still_6", div_cur, 6);
      wait_out(1, ok);
      chk("lit_ack_at_wrap", tick, 1);
      chk("lit_div_cur_3", div_cur, 3);
      #1;
      measure(3, 3);

      wait_out(0, ok);
      div_in = 8'd7;
      div_load = 1'b1;
      step(1);
      div_in = 8'd4;
      step(1);
      div_load = 1'b0;
      acks = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (div_ack) acks++;
      end
      chk("lit_single_ack", acks, 1);
      chk("lit_div_cur_4", div_cur, 4);
      #1;
      measure(4, 4);

      div_in = 8'd1;
      div_load = 1'b1;
      step(1);
      chk("lit_err_load1", div_err, 1);
      div_in = 8'd0;
      step(1);
      chk("lit_err_load0", div_err, 1);
      div_load = 1'b0;
      step(1);
      chk("lit_err_clear", div_err, 0);
      chk("lit_err_busy", busy, 0);
      chk("lit_err_div_cur", div_cur, 4);

      en = 1'b0;
      div_in = 8'd9;
      div_load = 1'b1;
      step(1);
      div_load = 1'b0;
      step(2);
      en = 1'b1;
      wait_out(0, ok);
      step(3);
      div_in = 8'd5;
      div_load = 1'b1;
      step(1);
      div_load = 1'b0;
      chk("lit_busy_n9", busy, 1);
      chk("lit_clk_hi_n9", clk_out, 1);
      #1 rst = 1'b1;
      #1;
      chk("lit_async_clk_out", clk_out, 0);
      chk("lit_async_tick", tick, 0);
      chk("lit_async_busy", busy, 0);
      chk("lit_async_div_cur", div_cur, 2);
      step(1);
      rst = 1'b0;
      measure(2, 2);

      for (int i = 0; i < 3000; i++) begin
         step(1);
         if ($urandom % 40 == 0) en = ~en;
         div_load = ($urandom % 8 == 0);
         div_in = W'($urandom_range(0, 12));
         rst = ($urandom % 600 == 0);
      end
      rst = 1'b0;
      div_load = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
      $fatal(1);
   end

endmodule
